// File: rtl/quad_encoder_counter.sv
// rtl/quad_encoder_counter.sv - quadrature decoder with input filter, index re-zero, error flag and velocity window
module quad_encoder_counter #(
  parameter int               CNT_W      = 16,
  parameter int               FILT_LEN   = 4,
  parameter int               VEL_PERIOD = 50000,
  parameter logic [CNT_W-1:0] RESET_VAL  = {1'b1, {(CNT_W-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_z,
  input  logic [1:0]       mode,
  input  logic             mode_ld,
  input  logic             idx_clr_en,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic [CNT_W-1:0] velocity,
  output logic             vel_valid,
  output logic             err
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int WCW = $clog2(VEL_PERIOD);
  localparam logic [WCW-1:0]   WLAST = WCW'(VEL_PERIOD - 1);
  localparam logic [CNT_W-1:0] VMAX  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] VMIN  = {1'b1, {(CNT_W-2){1'b0}}, 1'b1};

  logic [2:0] pins, s1, s2, filt, prev;
  assign pins = {enc_z, enc_b, enc_a};

  // Synchroniser flops are not reset so they keep tracking the pins through rst.
  always_ff @(posedge clk) begin
    s1 <= pins;
    s2 <= s1;
  end

  for (genvar i = 0; i < 3; i++) begin : g_filt
    logic           f;
    logic [FCW-1:0] fcnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        f    <= s2[i];
        fcnt <= '0;
      end else if (s2[i] == f) begin
        fcnt <= '0;
      end else if (fcnt == FCW'(FILT_LEN - 1)) begin
        f    <= s2[i];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
    assign filt[i] = f;
  end

  // Loading prev from the synchroniser during rst keeps the first decode after reset quiet.
  always_ff @(posedge clk) begin
    if (rst) prev <= s2;
    else     prev <= filt;
  end

  logic [1:0] mode_q;
  always_ff @(posedge clk) begin
    if (rst || mode_ld) mode_q <= mode;
  end

  logic       a_rise, a_fall, illegal, z_rise, step_up, step_dn;
  logic [1:0] pos_c, pos_p, pos_d;

  assign a_rise  = filt[0] & ~prev[0];
  assign a_fall  = ~filt[0] & prev[0];
  assign illegal = (filt[0] ^ prev[0]) & (filt[1] ^ prev[1]);
  assign z_rise  = filt[2] & ~prev[2];
  // Gray position 00->10->11->01 maps to 0..3, so a forward step is a +1 difference.
  assign pos_c   = {filt[1], filt[0] ^ filt[1]};
  assign pos_p   = {prev[1], prev[0] ^ prev[1]};
  assign pos_d   = pos_c - pos_p;

  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    if (!illegal) begin
      case (mode_q)
        2'b01: begin
          step_up = a_rise & ~filt[1];
          step_dn = a_rise & filt[1];
        end
        2'b10: begin
          step_up = (a_rise & ~filt[1]) | (a_fall & filt[1]);
          step_dn = (a_rise & filt[1]) | (a_fall & ~filt[1]);
        end
        2'b11: begin
          step_up = (pos_d == 2'd1);
          step_dn = (pos_d == 2'd3);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RESET_VAL;
      dir   <= 1'b0;
    end else begin
      if (idx_clr_en && z_rise) count <= RESET_VAL;
      else if (step_up)         count <= count + 1'b1;
      else if (step_dn)         count <= count - 1'b1;
      if (step_up)      dir <= 1'b1;
      else if (step_dn) dir <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (illegal) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  logic [CNT_W-1:0] acc, acc_nx;
  logic [WCW-1:0]   win;

  always_comb begin
    acc_nx = acc;
    if (step_up && acc != VMAX)      acc_nx = acc + 1'b1;
    else if (step_dn && acc != VMIN) acc_nx = acc - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      win       <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else if (win == WLAST) begin
      acc       <= '0;
      win       <= '0;
      velocity  <= acc_nx;
      vel_valid <= 1'b1;
    end else begin
      acc       <= acc_nx;
      win       <= win + 1'b1;
      vel_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// tb/tb_quad_encoder_counter.sv - directed vector bench for quad_encoder_counter
module tb_quad_encoder_counter;

  logic        clk = 1'b0, rst = 1'b1;
  logic        enc_a = 1'b0, enc_b = 1'b0, enc_z = 1'b0;
  logic [1:0]  mode = 2'b11;
  logic        mode_ld = 1'b0, idx_clr_en = 1'b0, err_clr = 1'b0;
  logic [15:0] count, velocity, count_w, velocity_w;
  logic        dir, vel_valid, err, dir_w, vel_valid_w, err_w;

  int n_cmp = 0, n_bad = 0;
  int pos = 0;

  always #5 clk = ~clk;

  quad_encoder_counter #(.CNT_W(16), .FILT_LEN(4), .VEL_PERIOD(100)) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .mode(mode), .mode_ld(mode_ld), .idx_clr_en(idx_clr_en), .err_clr(err_clr),
    .count(count), .dir(dir), .velocity(velocity), .vel_valid(vel_valid), .err(err)
  );

  // Second instance starts near zero so the wrap boundary is reachable in a short run.
  quad_encoder_counter #(.CNT_W(16), .FILT_LEN(4), .VEL_PERIOD(100), .RESET_VAL(16'd2)) dut_w (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .mode(mode), .mode_ld(mode_ld), .idx_clr_en(idx_clr_en), .err_clr(err_clr),
    .count(count_w), .dir(dir_w), .velocity(velocity_w), .vel_valid(vel_valid_w), .err(err_w)
  );

  typedef struct {
    logic [1:0]  mode;
    bit          fwd;
    logic [15:0] exp_count;
    logic        exp_dir;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    rst = 1'b1; mode = m; enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
    idx_clr_en = 1'b0; err_clr = 1'b0; mode_ld = 1'b0; pos = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_pos(input int d, input logic z, input int h);
    @(negedge clk);
    pos   = (pos + d + 4) % 4;
    enc_a = (pos == 1) || (pos == 2);
    enc_b = (pos == 2) || (pos == 3);
    enc_z = z;
    repeat (h) @(posedge clk);
    #1;
  endtask

  task automatic move(input int d, input int h);
    drive_pos(d, enc_z, h);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (vel_valid) ok = 1'b1;
    end
    chk({name, "_strobe_seen"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    logic [15:0] frozen;

    vecs[0] = '{2'b11, 1'b1, 16'h8028, 1'b1};
    vecs[1] = '{2'b01, 1'b1, 16'h800A, 1'b1};
    vecs[2] = '{2'b10, 1'b1, 16'h8014, 1'b1};
    vecs[3] = '{2'b11, 1'b0, 16'h7FD8, 1'b0};
    vecs[4] = '{2'b01, 1'b0, 16'h7FF6, 1'b0};
    vecs[5] = '{2'b10, 1'b0, 16'h7FEC, 1'b0};
    vecs[6] = '{2'b00, 1'b1, 16'h8000, 1'b0};

    do_reset(2'b11);
    #1;
    chk("rst_count", count, 16'h8000);
    chk("rst_dir", dir, 1'b0);
    chk("rst_velocity", velocity, 16'h0);
    chk("rst_vel_valid", vel_valid, 1'b0);
    chk("rst_err", err, 1'b0);

    for (int v = 0; v < 7; v++) begin
      do_reset(vecs[v].mode);
      repeat (40) move(vecs[v].fwd ? 1 : -1, 8);
      settle();
      chk($sformatf("vec%0d_count", v), count, vecs[v].exp_count);
      chk($sformatf("vec%0d_dir", v), dir, vecs[v].exp_dir);
      chk($sformatf("vec%0d_err", v), err, 1'b0);
    end

    // Latency: count must change exactly FILT_LEN+2 edges after the first sampling edge.
    do_reset(2'b11);
    @(negedge clk);
    enc_a = 1'b1; pos = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("lat_before", count, 16'h8000);
    @(posedge clk);
    #1;
    chk("lat_after", count, 16'h8001);

    // Three-cycle glitch on A is rejected.
    do_reset(2'b11);
    @(negedge clk);
    enc_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    enc_a = 1'b0;
    settle();
    chk("glitch_count", count, 16'h8000);

    // Illegal double transition, clear, then clear colliding with a new illegal event.
    do_reset(2'b11);
    @(negedge clk);
    enc_a = 1'b1; enc_b = 1'b1;
    settle();
    chk("illegal_err", err, 1'b1);
    chk("illegal_count", count, 16'h8000);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", err, 1'b0);
    @(negedge clk);
    enc_a = 1'b0; enc_b = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("set_beats_clr", err, 1'b1);
    chk("illegal2_count", count, 16'h8000);

    // Wrap in both directions on the low-reset instance.
    do_reset(2'b11);
    move(-1, 8);
    move(-1, 8);
    chk("wrap_zero", count_w, 16'h0000);
    move(-1, 8);
    chk("wrap_down", count_w, 16'hFFFF);
    chk("wrap_down_dir", dir_w, 1'b0);
    move(1, 8);
    chk("wrap_up", count_w, 16'h0000);
    chk("wrap_up_dir", dir_w, 1'b1);

    // Index clear against a coincident up step.
    do_reset(2'b11);
    repeat (291) move(1, 6);
    settle();
    chk("idx_preload", count, 16'h8123);
    drive_pos(1, 1'b1, 8);
    chk("idx_disabled", count, 16'h8124);
    drive_pos(-1, 1'b0, 8);
    chk("idx_back", count, 16'h8123);
    idx_clr_en = 1'b1;
    drive_pos(1, 1'b1, 8);
    chk("idx_clear", count, 16'h8000);
    chk("idx_clear_dir", dir, 1'b1);

    // Velocity windows of 100 cycles aligned to reset release.
    do_reset(2'b11);
    repeat (7) move(1, 8);
    wait_valid("win1");
    chk("win1_velocity", velocity, 16'd7);
    @(posedge clk);
    #1;
    chk("win1_strobe_one_cycle", vel_valid, 1'b0);
    repeat (3) move(-1, 8);
    wait_valid("win2");
    chk("win2_velocity", velocity, 16'hFFFD);
    @(negedge clk);
    mode = 2'b00; mode_ld = 1'b1;
    @(negedge clk);
    mode_ld = 1'b0;
    frozen = count;
    repeat (4) move(1, 8);
    settle();
    chk("mode_off_frozen", count, frozen);
    wait_valid("win3");
    chk("win3_velocity", velocity, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_encoder_counter.md
Name: quad_encoder_counter

Overview:
Parametrised quadrature encoder interface, the next generation of the team's single-channel encoder reader. Adds an input synchroniser, a glitch filter, runtime-reloadable x1/x2/x4 decode, index (Z) re-zeroing, illegal-transition detection and windowed velocity measurement. Sits between the encoder pins and the motor-control register bank; `count`, `velocity` and `err` are read by the control loop.

Parameters:
- CNT_W, 16, width of `count` and `velocity` in bits (min 8).
- FILT_LEN, 4, consecutive cycles a synchronised input must differ from its filtered value before it is accepted (min 1).
- VEL_PERIOD, 50000, clk cycles per velocity window (min 2).
- RESET_VAL, 2**(CNT_W-1), `count` value after reset or index clear.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- enc_a  in  1  encoder channel A, asynchronous
- enc_b  in  1  encoder channel B, asynchronous
- enc_z  in  1  encoder index, asynchronous
- mode  in  2  decode mode: 00 off, 01 x1, 10 x2, 11 x4
- mode_ld  in  1  load `mode` into the active-mode register
- idx_clr_en  in  1  enable re-zero of `count` on index
- err_clr  in  1  clear sticky `err`
- count  out  CNT_W  position counter, unsigned, modular
- dir  out  1  direction of last counted step: 1 up, 0 down
- velocity  out  CNT_W  signed step sum of the last completed window
- vel_valid  out  1  one-cycle strobe when `velocity` updates
- err  out  1  sticky illegal-transition flag

Behaviour:
- Reset is synchronous and active-high; clock is `clk`.
- Reset values: count=RESET_VAL, dir=0, velocity=0, vel_valid=0, err=0, window counter=0, step accumulator=0.
- During rst, active mode is loaded from `mode`. Sync and filter stages keep tracking the pins, with filtered value = synchronised value, so there is no spurious step after reset.
- Synchroniser: 2 flops per input (A, B, Z).
- Filter, per input:
  - The counter increments while synchronised != filtered and clears when they are equal.
  - On the FILT_LEN-th consecutive mismatch, filtered <= synchronised and the counter clears.
  - Pulses shorter than FILT_LEN cycles at the synchroniser output are rejected.
- Latency: a clean pin edge first sampled at clk edge N changes `count`/`dir` at edge N+FILT_LEN+2. With FILT_LEN=4 that is N+6.
- Decode uses the previous vs current filtered (A,B); the "prev" registers update every cycle.
- Mode x1:
  - A rise with B=0 → +1.
  - A rise with B=1 → -1.
  - No other transition counts.
- Mode x2:
  - Adds A fall with B=1 → +1.
  - Adds A fall with B=0 → -1.
- Mode x4:
  - Gray sequence (A,B) 00→10→11→01→00: each transition +1.
  - Reverse sequence: each transition -1.
- Mode 00: no steps counted; `count` is held; illegal detection stays active.
- Illegal transition (A and B filtered values both change in the same cycle), any mode including 00:
  - No step is counted.
  - err <= 1.
- err is sticky until err_clr. Same-cycle set and err_clr: set wins (err stays 1).
- Counter arithmetic: modulo 2^CNT_W. Up from all-ones wraps to 0; down from 0 wraps to all-ones. No flags are raised on wrap.
- dir updates only on a counted step.
- Index clear:
  - Trigger: idx_clr_en=1 and a filtered Z rising edge → count <= RESET_VAL.
  - This has priority over a step in the same cycle, but that step is still added to the velocity accumulator and updates dir.
- mode_ld=1 → active mode <= `mode`, effective from the next cycle. The count is not cleared.
- Velocity:
  - The window counter counts 0..VEL_PERIOD-1.
  - Every cycle, the accumulator adds the step (+1/0/-1), saturating at ±(2^(CNT_W-1)-1).
  - In the cycle the window counter = VEL_PERIOD-1:
    - velocity <= saturated(acc + step);
    - acc <= 0;
    - vel_valid=1 for that one cycle;
    - the window counter wraps to 0.
- Velocity is unaffected by index clears and count wrap.

Test Plan:
- Reset, then x4 mode with 10 forward Gray cycles (40 transitions), each level held 8 clk → count=0x8028, dir=1, err=0. Each step appears FILT_LEN+2 edges after the pin edge.
- Same stimulus in x1 → +10 (0x800A); in x2 → +20. Reverse stimulus in x4 → 0x7FD8, dir=0.
- 3-cycle glitch on A with FILT_LEN=4 → no count change. A and B toggled on the same clk and held → err=1 and count unchanged. Then err_clr → err=0. err_clr asserted with a new illegal event in the same cycle → err=1.
- Preload count via reverse x4 steps to 0x0000 from 0x8000 region, then 1 more down step → count=0xFFFF. Up step → 0x0000.
- idx_clr_en=1, count=0x8123, Z rising edge coinciding with an up step → count=0x8000, dir=1. With idx_clr_en=0 → count=0x8124.
- VEL_PERIOD=100, x4, 7 up steps in the window → vel_valid one cycle at window end, velocity=7. Next window with 3 down steps → velocity=0xFFFD. mode_ld to 00 mid-run → count frozen, next velocity=0.
